// File: rtl/hit_arbiter_if.sv
// Frame-rate signal bundle between the fight/punch logic and hit_arbiter.
// master drives hit/block/round_start and observes scoring; slave is the arbiter.
interface hit_arbiter_if;
  logic       hitP1;
  logic       hitP2;
  logic       blockP1;
  logic       blockP2;
  logic       round_start;
  logic [7:0] healthP1;
  logic [7:0] healthP2;
  logic       stunP1;
  logic       stunP2;
  logic       fight_active;
  logic       round_over;
  logic [1:0] winner;

  modport master (
    output hitP1, hitP2, blockP1, blockP2, round_start,
    input  healthP1, healthP2, stunP1, stunP2, fight_active, round_over, winner
  );

  modport slave (
    input  hitP1, hitP2, blockP1, blockP2, round_start,
    output healthP1, healthP2, stunP1, stunP2, fight_active, round_over, winner
  );
endinterface

// File: rtl/hit_arbiter.sv
// Round/health/stun arbiter for a two-player fighting game, one update per frame.
// Optional macro CHIP_DAMAGE_EN: unstunned lone blocks cost 1 health in FIGHT.
//
// state | meaning
// IDLE  | after reset, waiting for round_start
// FIGHT | hits accepted, health and stun tracked
// KO    | a player hit 0 health, counting KO_FRAMES
// DONE  | round finished, winner held until round_start
module hit_arbiter #(
  parameter int MAX_HEALTH  = 100,
  parameter int PUNCH_DMG   = 10,
  parameter int STUN_FRAMES = 20,
  parameter int KO_FRAMES   = 120
) (
  input  logic          frame_clk,
  input  logic          Reset,
  hit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FIGHT, KO, DONE} state_t;

  localparam int              CW          = 16;
  localparam logic [CW-1:0]   ONE         = CW'(1);
  localparam logic [CW-1:0]   STUN_LOAD   = CW'(STUN_FRAMES);
  localparam logic [CW-1:0]   KO_LOAD     = CW'(KO_FRAMES);
  localparam logic [8:0]      HEALTH_INIT = 9'(MAX_HEALTH);
  // Clamp damage to the 9-bit range so oversized parameters still saturate at 0.
  localparam logic [8:0]      DMG         = (PUNCH_DMG > 511) ? 9'd511 : 9'(PUNCH_DMG);

  state_t          r_state, w_state_nxt;
  logic [8:0]      r_health_p1, r_health_p2, w_h1_nxt, w_h2_nxt;
  logic [CW-1:0]   r_stun_p1, r_stun_p2, w_stun1_nxt, w_stun2_nxt;
  logic [CW-1:0]   r_ko_cnt, w_ko_nxt;
  logic [1:0]      r_winner, w_win_nxt;

  function automatic logic [8:0] sat_sub(input logic [8:0] h, input logic [8:0] d);
    return (h > d) ? (h - d) : 9'd0;
  endfunction

`ifndef CHIP_DAMAGE_EN
  logic w_unused_block;
  assign w_unused_block = bus.blockP1 ^ bus.blockP2;
`endif

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_health_p1 <= HEALTH_INIT;
      r_health_p2 <= HEALTH_INIT;
      r_stun_p1   <= '0;
      r_stun_p2   <= '0;
      r_ko_cnt    <= '0;
      r_winner    <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_health_p1 <= w_h1_nxt;
      r_health_p2 <= w_h2_nxt;
      r_stun_p1   <= w_stun1_nxt;
      r_stun_p2   <= w_stun2_nxt;
      r_ko_cnt    <= w_ko_nxt;
      r_winner    <= w_win_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_h1_nxt    = r_health_p1;
    w_h2_nxt    = r_health_p2;
    w_stun1_nxt = (r_stun_p1 != '0) ? (r_stun_p1 - ONE) : '0;
    w_stun2_nxt = (r_stun_p2 != '0) ? (r_stun_p2 - ONE) : '0;
    w_ko_nxt    = r_ko_cnt;
    w_win_nxt   = r_winner;
    case (r_state)
      IDLE, DONE: begin
        if (bus.round_start) begin
          w_state_nxt = FIGHT;
          w_h1_nxt    = HEALTH_INIT;
          w_h2_nxt    = HEALTH_INIT;
          w_stun1_nxt = '0;
          w_stun2_nxt = '0;
          w_win_nxt   = 2'b00;
        end
      end
      FIGHT: begin
        if (bus.hitP1 && r_stun_p1 == '0) begin
          w_h1_nxt    = sat_sub(r_health_p1, DMG);
          w_stun1_nxt = STUN_LOAD;
        end
`ifdef CHIP_DAMAGE_EN
        else if (bus.blockP1 && r_stun_p1 == '0) begin
          w_h1_nxt = sat_sub(r_health_p1, 9'd1);
        end
`endif
        if (bus.hitP2 && r_stun_p2 == '0) begin
          w_h2_nxt    = sat_sub(r_health_p2, DMG);
          w_stun2_nxt = STUN_LOAD;
        end
`ifdef CHIP_DAMAGE_EN
        else if (bus.blockP2 && r_stun_p2 == '0) begin
          w_h2_nxt = sat_sub(r_health_p2, 9'd1);
        end
`endif
        // KO is entered on the same edge that writes the zero health.
        if (w_h1_nxt == 9'd0 || w_h2_nxt == 9'd0) begin
          w_state_nxt = KO;
          w_ko_nxt    = KO_LOAD;
          w_win_nxt   = {w_h1_nxt == 9'd0, w_h2_nxt == 9'd0};
        end
      end
      KO: begin
        if (r_ko_cnt <= ONE) begin
          w_state_nxt = DONE;
          w_ko_nxt    = '0;
        end else begin
          w_ko_nxt = r_ko_cnt - ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.healthP1     = r_health_p1[7:0];
  assign bus.healthP2     = r_health_p2[7:0];
  assign bus.stunP1       = (r_stun_p1 != '0);
  assign bus.stunP2       = (r_stun_p2 != '0);
  assign bus.fight_active = (r_state == FIGHT);
  assign bus.round_over   = (r_state == DONE);
  assign bus.winner       = r_winner;

endmodule

// File: tb/tb_hit_arbiter.sv
// Self-checking bench for hit_arbiter: vector table plus multi-frame sequences,
// expected outputs queued at drive time and popped when the frame result is sampled.
module tb_hit_arbiter;

  logic frame_clk = 1'b0;
  logic Reset;

  hit_arbiter_if bus();

  hit_arbiter #(
    .MAX_HEALTH(100), .PUNCH_DMG(10), .STUN_FRAMES(20), .KO_FRAMES(120)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 frame_clk = ~frame_clk;

`ifdef CHIP_DAMAGE_EN
  localparam bit CHIP = 1'b1;
`else
  localparam bit CHIP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] h1;
    logic [7:0] h2;
    logic       s1;
    logic       s2;
    logic       fa;
    logic       ro;
    logic [1:0] win;
  } exp_t;

  typedef struct {
    string name;
    logic  rst, rs, hp1, hp2, bp1, bp2;
    exp_t  e;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  sb_q[$];
  string name_q[$];
  vec_t  tbl[8];

  function automatic exp_t mk(input int h1, input int h2, input bit s1, input bit s2,
                              input bit fa, input bit ro, input int w);
    exp_t r;
    r.h1 = 8'(h1); r.h2 = 8'(h2); r.s1 = s1; r.s2 = s2;
    r.fa = fa; r.ro = ro; r.win = 2'(w);
    return r;
  endfunction

  function automatic vec_t v(input string n, input logic rst, input logic rs,
                             input logic hp1, input logic hp2, input logic bp1,
                             input logic bp2, input exp_t e);
    vec_t r;
    r.name = n; r.rst = rst; r.rs = rs; r.hp1 = hp1; r.hp2 = hp2;
    r.bp1 = bp1; r.bp2 = bp2; r.e = e;
    return r;
  endfunction

  // Drive one frame at the falling edge, sample 1 time unit after the rising edge.
  task automatic frame(input string name, input logic rst, input logic rs,
                       input logic hp1, input logic hp2, input logic bp1,
                       input logic bp2, input exp_t e);
    exp_t  got, want;
    string nm;
    Reset = rst; bus.round_start = rs;
    bus.hitP1 = hp1; bus.hitP2 = hp2; bus.blockP1 = bp1; bus.blockP2 = bp2;
    sb_q.push_back(e);
    name_q.push_back(name);
    @(posedge frame_clk);
    #1;
    got  = {bus.healthP1, bus.healthP2, bus.stunP1, bus.stunP2,
            bus.fight_active, bus.round_over, bus.winner};
    want = sb_q.pop_front();
    nm   = name_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got h1=%0d h2=%0d s1=%b s2=%b fa=%b ro=%b win=%b, expected h1=%0d h2=%0d s1=%b s2=%b fa=%b ro=%b win=%b",
               nm, got.h1, got.h2, got.s1, got.s2, got.fa, got.ro, got.win,
               want.h1, want.h2, want.s1, want.s2, want.fa, want.ro, want.win);
    end
    @(negedge frame_clk);
  endtask

  // Ten simultaneous trades from full health, waiting out stun between them.
  task automatic trade_to_ko();
    for (int i = 1; i <= 10; i++) begin
      frame("trade", 0, 0, 1, 1, 0, 0,
            mk(100 - 10*i, 100 - 10*i, 1, 1, i < 10, 0, (i == 10) ? 3 : 0));
      if (i < 10) begin
        for (int k = 1; k <= 20; k++)
          frame("trade_gap", 0, 0, 0, 0, 0, 0,
                mk(100 - 10*i, 100 - 10*i, k < 20, k < 20, 1, 0, 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    bus.round_start = 1'b0;
    bus.hitP1 = 1'b0; bus.hitP2 = 1'b0; bus.blockP1 = 1'b0; bus.blockP2 = 1'b0;

    tbl[0] = v("reset",            1, 0, 0, 0, 0, 0, mk(100, 100, 0, 0, 0, 0, 0));
    tbl[1] = v("idle_hit_ignored", 0, 0, 1, 1, 1, 1, mk(100, 100, 0, 0, 0, 0, 0));
    tbl[2] = v("round_start",      0, 1, 0, 0, 0, 0, mk(100, 100, 0, 0, 1, 0, 0));
    tbl[3] = v("hit_p2",           0, 0, 0, 1, 0, 0, mk(100,  90, 0, 1, 1, 0, 0));
    tbl[4] = v("rs_in_fight",      0, 1, 0, 0, 0, 0, mk(100,  90, 0, 1, 1, 0, 0));
    tbl[5] = v("hit_block_p1",     0, 0, 1, 0, 1, 0, mk( 90,  90, 1, 1, 1, 0, 0));
    tbl[6] = v("block_p2_stunned", 0, 0, 0, 0, 0, 1, mk( 90,  90, 1, 1, 1, 0, 0));
    tbl[7] = v("hit_p2_stunned",   0, 0, 0, 1, 0, 0, mk( 90,  90, 1, 1, 1, 0, 0));

    @(negedge frame_clk);
    for (int i = 0; i < 8; i++)
      frame(tbl[i].name, tbl[i].rst, tbl[i].rs, tbl[i].hp1, tbl[i].hp2,
            tbl[i].bp1, tbl[i].bp2, tbl[i].e);

    // P2 stun (loaded at hit_p2) now at 16, P1 stun at 18.
    for (int k = 1; k <= 16; k++)
      frame("stun_decay", 0, 0, 0, 0, 0, 0, mk(90, 90, 1, k < 16, 1, 0, 0));
    frame("hit_p2_after_stun", 0, 0, 0, 1, 0, 0, mk(90, 80, 1, 1, 1, 0, 0));
    frame("p1_stun_ends",      0, 0, 0, 0, 0, 0, mk(90, 80, 0, 1, 1, 0, 0));
    frame("hit_p1_after_stun", 0, 0, 1, 0, 0, 0, mk(80, 80, 1, 1, 1, 0, 0));

    frame("reset_mid_fight",   1, 0, 1, 1, 0, 0, mk(100, 100, 0, 0, 0, 0, 0));
    frame("round_start_2",     0, 1, 0, 0, 0, 0, mk(100, 100, 0, 0, 1, 0, 0));
    trade_to_ko();

    // KO lasts 120 frames; hits and blocks must be ignored throughout.
    for (int k = 1; k <= 120; k++)
      frame("ko_count", 0, 0, 1, 0, 0, 1, mk(0, 0, k < 20, k < 20, 0, k == 120, 3));
    frame("done_hold",        0, 0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 1, 3));
    frame("restart_from_done", 0, 1, 0, 0, 1, 0, mk(100, 100, 0, 0, 1, 0, 0));
    frame("block_p1_alone",   0, 0, 0, 0, 1, 0, mk(CHIP ? 99 : 100, 100, 0, 0, 1, 0, 0));

    frame("reset_2",          1, 0, 0, 0, 0, 0, mk(100, 100, 0, 0, 0, 0, 0));
    frame("round_start_3",    0, 1, 0, 0, 0, 0, mk(100, 100, 0, 0, 1, 0, 0));
    trade_to_ko();
    for (int k = 1; k <= 5; k++)
      frame("ko_partial", 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 0, 0, 3));
    frame("reset_mid_ko",     1, 1, 1, 1, 1, 1, mk(100, 100, 0, 0, 0, 0, 0));
    frame("idle_after_reset", 0, 0, 0, 0, 0, 0, mk(100, 100, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
